fourway_direction_resolver: RTL
===============================

// Module: fourway_direction_resolver
// PURPOSE
//  Sequential 4-way restrictor for raw 8-way/keyboard/hitbox input: {up,down,left,right} -> at most one direction.
//  Resolves opposite directions per axis by last-input-wins; resolves diagonals by stickiness plus an optional timed hand-over.
//  Sits between the input mux and game joystick ports of 4-way cores; replaces combinational per-axis cleaning where state is needed.
// PARAMETERS
//  DIAG_DELAY  default 4  ce ticks a diagonal must persist before output moves to the other axis; 0 = never move (fully sticky)
//  CNT_W       default 8  width of diagonal tick counter; DIAG_DELAY must be < 2**CNT_W
// PORTS
//  clk        in   1  core clock
//  reset      in   1  synchronous, active-high reset
//  ce         in   1  sample enable (1 = every clk, or a per-frame pulse); all state holds when low
//  dirinput   in   4  raw {up,down,left,right}, active-high, already synchronous to clk
//  diroutput  out  4  resolved {up,down,left,right}: one-hot or all-zero, registered
//  changed    out  1  one-clk pulse on the edge where diroutput takes a new value
// BEHAVIOUR
//  Reset (overrides ce): diroutput=0, changed=0, state=NONE, prev=0, v_last=UP, h_last=LEFT, axis_last=VERT, cnt=0, diag_done=0.
//  All updates below occur only on clk edges with ce=1; ce=0 -> all registers hold, changed=0.
//  Edge detect: rise = dirinput & ~prev; prev <= dirinput. Input held through reset release counts as a rise on first ce.
//  Axis history: rise up only -> v_last=UP; rise down only -> v_last=DOWN; both same tick -> unchanged. Same for left/right -> h_last.
//   any vertical rise and no horizontal rise -> axis_last=VERT; horizontal-only -> HORZ; both -> unchanged.
//  SOCD clean (comb, from current dirinput): if up&down keep only v_last dir; if left&right keep only h_last dir -> c[3:0].
//  State machine: NONE, UP, DOWN, LEFT, RIGHT; diroutput is state decoded one-hot (NONE = 4'b0000).
//   c == 0              -> NONE; cnt=0; diag_done=0.
//   c single bit        -> that direction (immediate, even from another direction); cnt=0; diag_done=0.
//   c diagonal (1V+1H):
//    state is one of the two -> hold; if DIAG_DELAY!=0 and !diag_done: cnt++; on cnt reaching DIAG_DELAY
//      move to the other diagonal component, cnt=0, diag_done=1 (no further moves until diagonal ends).
//    state NONE or neither component -> take component on axis_last; cnt=0; diag_done=0.
//  Latency: one clk from a ce-qualified input sample to diroutput; changed asserted in that same cycle iff value differs.
//  cnt saturates at DIAG_DELAY; never wraps. Output is never two bits and never an opposite pair.
//  Reset asserted mid-diagonal or mid-count: everything returns to reset values the next edge; no stale history survives.
// TESTING
//  1 reset, ce=1, dirinput=0010 -> next clk diroutput=0010, changed=1; following clk changed=0, output holds.
//  2 hold left(0010), add right -> 0011: output 0001 (right newest); release right -> 0010 immediately; changed pulses each time.
//  3 DIAG_DELAY=4: up held (1000), add right (1001) -> stays 1000 for 3 ce ticks, 0001 on 4th tick; holds 0001 thereafter.
//  4 DIAG_DELAY=0: from 0000 apply 1001 with up rising first tick, right next -> output 1000 forever while 1001 held.
//  5 ce pulsed every 8 clks: input changes between pulses ignored; output/changed only move on ce edges.
//  6 reset during diagonal count (cnt=2): diroutput=0, changed=0; with 1001 held after release -> both rise same tick, axis_last=VERT -> 1000.

Source files
------------

// File: rtl/fourway_direction_resolver.sv
// Sequential 4-way restrictor: reduces raw {up,down,left,right} to at most one
// direction using last-input-wins per axis and sticky, optionally timed, diagonals.
module fourway_direction_resolver #(
  parameter int unsigned DIAG_DELAY = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [3:0] dirinput,
  output logic [3:0] diroutput,
  output logic       changed
);

  // Handshake: none. Every register advances only on clk edges with ce=1;
  // diroutput is the registered state, changed is a one-clk pulse.

  typedef enum logic [2:0] {
    ST_NONE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_LEFT  = 3'd3,
    ST_RIGHT = 3'd4
  } state_e;

  localparam logic             TIMED   = (DIAG_DELAY != 0);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DIAG_DELAY);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // History encodings: v_last 0=UP 1=DOWN, h_last 0=LEFT 1=RIGHT, axis_last 0=VERT 1=HORZ
  state_e           state_q, state_d;
  logic [3:0]       prev_q;
  logic             v_last_q, v_last_d;
  logic             h_last_q, h_last_d;
  logic             axis_last_q, axis_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             diag_done_q, diag_done_d;
  logic             changed_q;

  logic [3:0]       rise;
  logic [3:0]       clean;
  logic             v_any_rise, h_any_rise;
  logic             is_diag;
  logic [CNT_W-1:0] cnt_inc;
  state_e           v_sel, h_sel;

  // Edge detect and per-axis history; the updated history is used this same
  // tick so a freshly pressed direction wins without an extra cycle.
  always_comb begin
    rise        = dirinput & ~prev_q;
    v_any_rise  = rise[3] | rise[2];
    h_any_rise  = rise[1] | rise[0];

    v_last_d    = v_last_q;
    h_last_d    = h_last_q;
    axis_last_d = axis_last_q;

    if (rise[3] && !rise[2]) begin
      v_last_d = 1'b0;
    end else if (rise[2] && !rise[3]) begin
      v_last_d = 1'b1;
    end

    if (rise[1] && !rise[0]) begin
      h_last_d = 1'b0;
    end else if (rise[0] && !rise[1]) begin
      h_last_d = 1'b1;
    end

    if (v_any_rise && !h_any_rise) begin
      axis_last_d = 1'b0;
    end else if (h_any_rise && !v_any_rise) begin
      axis_last_d = 1'b1;
    end
  end

  // Opposite-pair cleaning: keep only the most recently pressed side.
  always_comb begin
    clean = dirinput;
    if (dirinput[3] && dirinput[2]) begin
      clean[3] = ~v_last_d;
      clean[2] =  v_last_d;
    end
    if (dirinput[1] && dirinput[0]) begin
      clean[1] = ~h_last_d;
      clean[0] =  h_last_d;
    end
  end

  always_comb begin
    v_sel = ST_NONE;
    if (clean[3]) begin
      v_sel = ST_UP;
    end else if (clean[2]) begin
      v_sel = ST_DOWN;
    end

    h_sel = ST_NONE;
    if (clean[1]) begin
      h_sel = ST_LEFT;
    end else if (clean[0]) begin
      h_sel = ST_RIGHT;
    end

    is_diag = (v_sel != ST_NONE) && (h_sel != ST_NONE);
    cnt_inc = cnt_q + ONE_C;
  end

  // Next-state logic for the direction FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    diag_done_d = diag_done_q;

    if (clean == 4'b0000) begin
      state_d     = ST_NONE;
      cnt_d       = '0;
      diag_done_d = 1'b0;
    end else if (!is_diag) begin
      state_d     = (v_sel != ST_NONE) ? v_sel : h_sel;
      cnt_d       = '0;
      diag_done_d = 1'b0;
    end else if (state_q == v_sel || state_q == h_sel) begin
      // Sticky diagonal; hand over once to the other component after the delay.
      if (TIMED && !diag_done_q) begin
        if (cnt_inc >= DELAY_C) begin
          state_d     = (state_q == v_sel) ? h_sel : v_sel;
          cnt_d       = '0;
          diag_done_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end else begin
      state_d     = axis_last_d ? h_sel : v_sel;
      cnt_d       = '0;
      diag_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_NONE;
      prev_q      <= 4'b0000;
      v_last_q    <= 1'b0;
      h_last_q    <= 1'b0;
      axis_last_q <= 1'b0;
      cnt_q       <= '0;
      diag_done_q <= 1'b0;
      changed_q   <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      prev_q      <= dirinput;
      v_last_q    <= v_last_d;
      h_last_q    <= h_last_d;
      axis_last_q <= axis_last_d;
      cnt_q       <= cnt_d;
      diag_done_q <= diag_done_d;
      changed_q   <= (state_d != state_q);
    end else begin
      changed_q   <= 1'b0;
    end
  end

  always_comb begin
    diroutput = 4'b0000;
    case (state_q)
      ST_UP:    diroutput = 4'b1000;
      ST_DOWN:  diroutput = 4'b0100;
      ST_LEFT:  diroutput = 4'b0010;
      ST_RIGHT: diroutput = 4'b0001;
      default:  diroutput = 4'b0000;
    endcase
  end

  assign changed = changed_q;

endmodule
